// File: rtl/mac_seq.sv
// mac_seq: operand sequencer and result collector for a pipelined signed MAC.
// Streams N operand pairs into the MAC (a/b/clear) and collects each finished
// dot product from z into a 2-entry result FIFO drained over valid/ready.
module mac_seq #(
    parameter int aBits   = 10,
    parameter int zBits   = 22,
    parameter int lenBits = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [lenBits-1:0]       cfg_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [aBits-1:0]  in_a,
    input  logic signed [aBits-1:0]  in_b,
    output logic signed [aBits-1:0]  mac_a,
    output logic signed [aBits-1:0]  mac_b,
    output logic                     mac_clear,
    input  logic signed [zBits-1:0]  mac_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [zBits-1:0]  out_z,
    output logic                     busy
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [lenBits-1:0]      len_q, len_d;
    logic [lenBits-1:0]      cnt_q, cnt_d;
    logic [1:0]              credits_q, credits_d;
    logic signed [aBits-1:0] mac_a_q, mac_a_d;
    logic signed [aBits-1:0] mac_b_q, mac_b_d;
    logic                    clr_p1_q, clr_p1_d;
    logic                    mac_clear_q, mac_clear_d;
    logic                    last_p1_q, last_p1_d;
    logic                    last_p2_q, last_p2_d;
    logic                    last_p3_q, last_p3_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              fill_q, fill_d;
    logic signed [zBits-1:0] fifo_q [2];
    logic signed [zBits-1:0] fifo_d [2];

    logic is_last;
    logic accept;
    logic push;
    logic pop;

    // The last pair of a vector may only be taken when a FIFO slot is reserved for its result.
    assign is_last   = (cnt_q == len_q - lenBits'(1));
    assign in_ready  = (state_q == S_RUN) && !(is_last && (credits_q == 2'd0));
    assign accept    = in_valid && in_ready;
    assign out_valid = (fill_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = last_p3_q;
    assign out_z     = out_valid ? fifo_q[rd_ptr_q] : '0;
    assign busy      = (state_q == S_RUN);
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign mac_clear = mac_clear_q;

    // Next-state logic: sequencing FSM, credits, operand/clear/capture pipes and FIFO.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        credits_d   = credits_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        fifo_d      = fifo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && (cfg_len != '0)) begin
                    state_d = S_RUN;
                    len_d   = cfg_len;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (is_last) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + lenBits'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case ({accept && is_last, pop})
            2'b10:   credits_d = credits_q - 2'd1;
            2'b01:   credits_d = credits_q + 2'd1;
            default: credits_d = credits_q;
        endcase

        // Gaps feed zero operands so the accumulator just adds zero.
        mac_a_d     = accept ? in_a : '0;
        mac_b_d     = accept ? in_b : '0;
        clr_p1_d    = accept && (cnt_q == '0);
        mac_clear_d = clr_p1_q;
        last_p1_d   = accept && is_last;
        last_p2_d   = last_p1_q;
        last_p3_d   = last_p2_q;

        if (push) begin
            fifo_d[wr_ptr_q] = mac_z;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    // Control and MAC-drive registers; reset aborts any vector in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            credits_q   <= 2'd2;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            clr_p1_q    <= 1'b0;
            mac_clear_q <= 1'b0;
            last_p1_q   <= 1'b0;
            last_p2_q   <= 1'b0;
            last_p3_q   <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fill_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            credits_q   <= credits_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            clr_p1_q    <= clr_p1_d;
            mac_clear_q <= mac_clear_d;
            last_p1_q   <= last_p1_d;
            last_p2_q   <= last_p2_d;
            last_p3_q   <= last_p3_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
        end
    end

    // Result storage; contents are only observable through out_z when non-empty.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: drives mac_seq with directed and random vectors through a
// behavioural MAC, and checks every cycle against a dot-product model.
module tb_mac_seq;

    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         cfg_len;
    logic               in_valid;
    logic               in_ready;
    logic signed [9:0]  in_a;
    logic signed [9:0]  in_b;
    logic signed [9:0]  mac_a;
    logic signed [9:0]  mac_b;
    logic               mac_clear;
    logic signed [21:0] mac_z;
    logic               out_valid;
    logic               out_ready;
    logic [21:0]        out_z;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    mac_seq #(.aBits(10), .zBits(22), .lenBits(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clear(mac_clear), .mac_z(mac_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: product register, then accumulator with synchronous clear.
    logic signed [19:0] mac_p;
    logic signed [21:0] mac_acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_p   <= '0;
            mac_acc <= '0;
        end else begin
            mac_p   <= mac_a * mac_b;
            mac_acc <= mac_clear ? 22'(mac_p) : mac_acc + 22'(mac_p);
        end
    end
    assign mac_z = mac_acc;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct { longint v; int t; } res_t;
    res_t   rq[$];
    longint got[$];
    bit     m_run;
    int     m_n, m_k, m_pend;
    longint m_acc;
    longint ea, eb;
    bit     clr_now, clr_nxt;
    int     cyc = 0;
    int     last_acc_cyc = 0;
    int     rise_cyc = 0;
    bit     prev_ov;
    int     clr_cnt = 0;

    // Compare process: mid-cycle check of every output, then advance the model.
    always @(negedge clk) begin
        bit     exp_ir, exp_ov, was_run, clr_new;
        longint exp_oz;
        if (rst) begin
            chk("rst_in_ready", longint'(in_ready), 0);
            chk("rst_busy", longint'(busy), 0);
            chk("rst_mac_a", longint'(mac_a), 0);
            chk("rst_mac_b", longint'(mac_b), 0);
            chk("rst_mac_clear", longint'(mac_clear), 0);
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_out_z", longint'(out_z), 0);
            rq.delete();
            m_run = 0; m_n = 0; m_k = 0; m_pend = 0; m_acc = 0;
            ea = 0; eb = 0; clr_now = 0; clr_nxt = 0; prev_ov = 0;
        end else begin
            exp_ir = m_run && !((m_k == m_n - 1) && (m_pend >= 2));
            exp_ov = (rq.size() > 0) && (rq[0].t <= cyc);
            exp_oz = exp_ov ? rq[0].v : 0;
            chk("in_ready", longint'(in_ready), longint'(exp_ir));
            chk("busy", longint'(busy), longint'(m_run));
            chk("mac_a", longint'(mac_a), ea);
            chk("mac_b", longint'(mac_b), eb);
            chk("mac_clear", longint'(mac_clear), longint'(clr_now));
            chk("out_valid", longint'(out_valid), longint'(exp_ov));
            chk("out_z", longint'(out_z), exp_oz);
            if (mac_clear) clr_cnt++;
            if (out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = out_valid;

            was_run = m_run;
            clr_new = 0;
            if (in_valid && exp_ir) begin
                if (m_k == 0) m_acc = 0;
                m_acc += longint'(in_a) * longint'(in_b);
                ea = longint'(in_a);
                eb = longint'(in_b);
                clr_new = (m_k == 0);
                if (m_k == m_n - 1) begin
                    rq.push_back('{m_acc & 64'h3FFFFF, cyc + 4});
                    m_pend++;
                    m_run = 0;
                    m_k = 0;
                    last_acc_cyc = cyc;
                end else begin
                    m_k++;
                end
            end else begin
                ea = 0;
                eb = 0;
            end
            clr_now = clr_nxt;
            clr_nxt = clr_new;
            if (exp_ov && out_ready) begin
                got.push_back(rq[0].v);
                rq.pop_front();
                m_pend--;
            end
            if (!was_run && start && (cfg_len != 0)) begin
                m_run = 1;
                m_n = int'(cfg_len);
                m_k = 0;
            end
        end
        cyc++;
    end

    // Random backpressure when enabled
    bit rnd_or = 0;
    always begin
        @(posedge clk);
        #1;
        if (rnd_or) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_vec(input int n);
        int g;
        g = 0;
        while (busy && g < 2000) begin
            tick();
            g++;
        end
        if (g >= 2000) chk("start_timeout", 1, 0);
        start = 1'b1;
        cfg_len = 8'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int gap, input bit stray);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_a = 10'(a);
        in_b = 10'(b);
        while (!in_ready && g < 1000) begin
            tick();
            g++;
        end
        if (g >= 1000) chk("send_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            if (stray && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                cfg_len = 8'($urandom_range(0, 255));
            end
            tick();
            start = 1'b0;
        end
    endtask

    function automatic longint last_got();
        return (got.size() > 0) ? got[got.size() - 1] : -1;
    endfunction

    initial begin
        int n0, gs;
        rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Zero-length start is ignored
        start = 1'b1; cfg_len = 8'd0;
        tick();
        start = 1'b0;
        chk("len0_busy", longint'(busy), 0);

        // Basic vector
        clr_cnt = 0;
        start_vec(3);
        send(1, 2, 0, 0);
        send(3, 4, 0, 0);
        send(-5, 6, 0, 0);
        repeat (8) tick();
        chk("basic_z", last_got(), 64'h3FFFF0);
        chk("basic_latency", longint'(rise_cyc - last_acc_cyc), 4);
        chk("basic_clear_count", longint'(clr_cnt), 1);

        // Same vector with input gaps
        start_vec(3);
        send(1, 2, 2, 1);
        send(3, 4, 2, 1);
        send(-5, 6, 2, 0);
        repeat (6) tick();
        chk("gap_z", last_got(), 64'h3FFFF0);

        // Single pair extremes
        start_vec(1);
        send(-512, 511, 0, 0);
        repeat (6) tick();
        chk("single_z", last_got(), 64'h3C0200);

        // Accumulator wrap
        start_vec(8);
        for (int i = 0; i < 8; i++) send(-512, -512, 0, 0);
        repeat (6) tick();
        chk("wrap_z", last_got(), 64'h200000);

        // Backpressure: two buffered results, third stalls at its last pair
        n0 = got.size();
        out_ready = 1'b0;
        for (int v = 0; v < 2; v++) begin
            start_vec(2);
            send(1, 1, 0, 0);
            send(1, 1, 0, 0);
        end
        repeat (6) tick();
        start_vec(2);
        send(1, 1, 0, 0);
        in_valid = 1'b1; in_a = 10'sd1; in_b = 10'sd1;
        chk("bp_stall", longint'(in_ready), 0);
        tick();
        chk("bp_stall_hold", longint'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_resume", longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("bp_count", longint'(got.size() - n0), 3);
        if (got.size() >= 3) begin
            chk("bp_z0", got[got.size() - 3], 2);
            chk("bp_z1", got[got.size() - 2], 2);
            chk("bp_z2", got[got.size() - 1], 2);
        end

        // Reset in the middle of a vector
        start_vec(4);
        send(7, 7, 0, 0);
        send(9, 9, 0, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_mac_a", longint'(mac_a), 0);
        chk("mid_rst_mac_clear", longint'(mac_clear), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        n0 = got.size();
        start_vec(2);
        send(3, 3, 0, 0);
        send(4, 4, 0, 0);
        repeat (8) tick();
        chk("post_rst_count", longint'(got.size() - n0), 1);
        chk("post_rst_z", last_got(), 25);

        // Randomized vectors with random gaps and backpressure
        rnd_or = 1;
        for (int v = 0; v < 40; v++) begin
            int n;
            n = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; cfg_len = 8'd0;
                tick();
                start = 1'b0;
            end
            start_vec(n);
            for (int i = 0; i < n; i++) begin
                gs = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
                send($urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512, gs, i < n - 1);
            end
        end

        // Drain
        rnd_or = 0;
        tick();
        out_ready = 1'b1;
        gs = 0;
        while (rq.size() > 0 && gs < 100) begin
            tick();
            gs++;
        end
        chk("drain_done", longint'(rq.size()), 0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
